// File: rtl/sbox_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sbox_arbiter_if
// Purpose  : Request/response bundle between the DES round engines and the
//            shared S-box arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface sbox_arbiter_if #(
    parameter int TAGW = 4
) ();
    logic [1:0]          req_valid;
    logic [95:0]         req_data;   // {req_data1, req_data0}
    logic [2*TAGW-1:0]   req_tag;    // {req_tag1, req_tag0}
    logic [1:0]          req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_data;
    logic                rsp_id;
    logic [TAGW-1:0]     rsp_tag;

    modport slave (
        input  req_valid, req_data, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_tag
    );

    modport master (
        output req_valid, req_data, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_tag
    );
endinterface
`default_nettype wire

// File: rtl/sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sbox_arbiter
// Purpose  : Round-robin sharing of eight DES S-box ROMs between two requesters
//            with an in-order, back-pressured response buffer.
// Revision : 1.0  initial release
// ============================================================================
module sbox_arbiter #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    sbox_arbiter_if.slave    bus,
    output logic [15:0]      o_sbox_row,
    output logic [31:0]      o_sbox_col,
    input  wire logic [31:0] i_sbox_dout
);

    localparam int c_cw = $clog2(DEPTH + 1);
    localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_ew = 32 + 1 + TAGW;
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);
    localparam logic [c_pw-1:0] c_last  = c_pw'(DEPTH - 1);

    // Outstanding lookups: every stage from grant until the response pops.
    logic [c_cw-1:0]  r_cnt;
    logic [c_cw-1:0]  r_occ;
    logic [c_pw-1:0]  r_wptr;
    logic [c_pw-1:0]  r_rptr;
    logic [c_ew-1:0]  r_mem [DEPTH];
    logic             r_ptr;

    logic             r_a_valid;
    logic             r_a_id;
    logic [TAGW-1:0]  r_a_tag;
    logic             r_b_valid;
    logic             r_b_id;
    logic [TAGW-1:0]  r_b_tag;
    logic             r_c_valid;
    logic [31:0]      r_c_data;
    logic             r_c_id;
    logic [TAGW-1:0]  r_c_tag;

    logic             w_rsp_valid;
    logic             w_pop;
    logic             w_room;
    logic [1:0]       w_gnt;
    logic             w_any;
    logic [47:0]      w_req_data;
    logic [TAGW-1:0]  w_req_tag;
    logic [15:0]      w_row;
    logic [31:0]      w_col;
    logic [c_ew-1:0]  w_head;

    assign w_rsp_valid = (r_occ != '0);
    assign w_pop       = w_rsp_valid & bus.rsp_ready;
    // A pop this cycle frees a slot for a grant in the same cycle.
    assign w_room      = rstn & ((r_cnt < c_depth) | w_pop);

    assign w_gnt[0] = w_room & bus.req_valid[0] & (~bus.req_valid[1] | ~r_ptr);
    assign w_gnt[1] = w_room & bus.req_valid[1] & (~bus.req_valid[0] |  r_ptr);
    assign w_any    = |w_gnt;
    assign bus.req_ready = w_gnt;

    assign w_req_data = w_gnt[1] ? bus.req_data[95:48] : bus.req_data[47:0];
    assign w_req_tag  = w_gnt[1] ? bus.req_tag[2*TAGW-1:TAGW] : bus.req_tag[TAGW-1:0];

    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_split
            logic [5:0] w_b;
            assign w_b = w_req_data[47-6*k -: 6];
            assign w_row[15-2*k -: 2] = {w_b[5], w_b[0]};
            assign w_col[31-4*k -: 4] = w_b[4:1];
        end
    endgenerate

    // Address, arbitration and lookup pipeline.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_sbox_row <= '0;
            o_sbox_col <= '0;
            r_ptr      <= 1'b0;
            r_a_valid  <= 1'b0;
            r_a_id     <= 1'b0;
            r_a_tag    <= '0;
            r_b_valid  <= 1'b0;
            r_b_id     <= 1'b0;
            r_b_tag    <= '0;
            r_c_valid  <= 1'b0;
            r_c_data   <= '0;
            r_c_id     <= 1'b0;
            r_c_tag    <= '0;
        end else begin
            if (w_any) begin
                o_sbox_row <= w_row;
                o_sbox_col <= w_col;
                r_a_id     <= w_gnt[1];
                r_a_tag    <= w_req_tag;
                r_ptr      <= w_gnt[0];
            end
            r_a_valid <= w_any;
            r_b_valid <= r_a_valid;
            r_b_id    <= r_a_id;
            r_b_tag   <= r_a_tag;
            r_c_valid <= r_b_valid;
            if (r_b_valid) begin
                r_c_data <= i_sbox_dout;
                r_c_id   <= r_b_id;
                r_c_tag  <= r_b_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_occ  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_cnt <= r_cnt + {{(c_cw-1){1'b0}}, w_any} - {{(c_cw-1){1'b0}}, w_pop};
            r_occ <= r_occ + {{(c_cw-1){1'b0}}, r_c_valid} - {{(c_cw-1){1'b0}}, w_pop};
            if (r_c_valid) begin
                r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_c_valid) begin
            r_mem[r_wptr] <= {r_c_data, r_c_id, r_c_tag};
        end
    end

    // Storage is not reset, so the head is masked while the buffer is empty.
    assign w_head        = r_mem[r_rptr];
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = w_rsp_valid ? w_head[c_ew-1 -: 32] : 32'h0;
    assign bus.rsp_id    = w_rsp_valid ? w_head[TAGW] : 1'b0;
    assign bus.rsp_tag   = w_rsp_valid ? w_head[TAGW-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_arbiter
// Purpose  : Scoreboard bench for sbox_arbiter with a DES S-box ROM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sbox_arbiter;
    localparam int DEPTH = 4;
    localparam int TAGW  = 4;

    // DES S1..S8, row-major, entry 0 in the MSBs.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
    };

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] sbox_row;
    logic [31:0] sbox_col;
    logic [31:0] sbox_dout;

    always #5 clk = ~clk;

    sbox_arbiter_if #(.TAGW(TAGW)) bus ();

    sbox_arbiter #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .o_sbox_row  (sbox_row),
        .o_sbox_col  (sbox_col),
        .i_sbox_dout (sbox_dout)
    );

    function automatic logic [3:0] sb(input int k, input logic [1:0] row, input logic [3:0] col);
        logic [255:0] t;
        int idx;
        t   = SBOX[k];
        idx = int'(row) * 16 + int'(col);
        return t[255-4*idx -: 4];
    endfunction

    function automatic logic [31:0] golden(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  b;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            b = d[47-6*k -: 6];
            r[31-4*k -: 4] = sb(k, {b[5], b[0]}, b[4:1]);
        end
        return r;
    endfunction

    function automatic logic [15:0] split_row(input logic [47:0] d);
        logic [15:0] r;
        logic [5:0]  b;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            b = d[47-6*k -: 6];
            r[15-2*k -: 2] = {b[5], b[0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] split_col(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  b;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            b = d[47-6*k -: 6];
            r[31-4*k -: 4] = b[4:1];
        end
        return r;
    endfunction

    // ROM bank: one-cycle registered read, synchronous reset to zero.
    always @(posedge clk) begin
        if (!rstn) begin
            sbox_dout <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                sbox_dout[31-4*k -: 4] <= sb(k, sbox_row[15-2*k -: 2], sbox_col[31-4*k -: 4]);
            end
        end
    end

    int nrun  = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nrun++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0]     data;
        logic            id;
        logic [TAGW-1:0] tag;
    } exp_t;

    exp_t        sbq[$];
    int          gorder[$];
    int          gcnt[2];
    logic        last_g = 1'b0;
    logic [47:0] last_gdata;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [TAGW:0] prev_idtag;

    // Monitor: pushes expectations on accept, pops and compares on response.
    initial begin
        exp_t e;
        int   i;
        gcnt[0] = 0;
        gcnt[1] = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                sbq.delete();
                prev_hold = 1'b0;
                last_g    = 1'b0;
            end else begin
                if (last_g) begin
                    check("sbox_row split", sbox_row, split_row(last_gdata));
                    check("sbox_col split", sbox_col, split_col(last_gdata));
                end
                if (prev_hold) begin
                    check("rsp_valid held", bus.rsp_valid, 1);
                    check("rsp_data held", bus.rsp_data, prev_data);
                    check("rsp id/tag held", {bus.rsp_id, bus.rsp_tag}, prev_idtag);
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sbq.size() == 0) begin
                        nrun++;
                        nfail++;
                        $display("FAIL unexpected rsp: got data %h id %0d tag %0h, expected none",
                                 bus.rsp_data, bus.rsp_id, bus.rsp_tag);
                    end else begin
                        e = sbq.pop_front();
                        check("rsp_data", bus.rsp_data, e.data);
                        check("rsp id/tag", {bus.rsp_id, bus.rsp_tag}, {e.id, e.tag});
                    end
                end
                prev_hold  = bus.rsp_valid && !bus.rsp_ready;
                prev_data  = bus.rsp_data;
                prev_idtag = {bus.rsp_id, bus.rsp_tag};
                last_g     = 1'b0;
                if (bus.req_ready != 2'b00) begin
                    check("req_ready onehot", $onehot(bus.req_ready), 1);
                    check("req_ready without valid", bus.req_ready & ~bus.req_valid, 0);
                    i          = bus.req_ready[1] ? 1 : 0;
                    e.data     = golden(bus.req_data[48*i +: 48]);
                    e.id       = bus.req_ready[1];
                    e.tag      = bus.req_tag[TAGW*i +: TAGW];
                    sbq.push_back(e);
                    gorder.push_back(i);
                    gcnt[i]++;
                    last_g     = 1'b1;
                    last_gdata = bus.req_data[48*i +: 48];
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0;
        repeat (n) tick();
        rstn = 1'b1;
    endtask

    task automatic rand_data();
        bus.req_data = {$urandom, $urandom, $urandom};
        bus.req_tag  = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_drain();
        int n = 0;
        bus.rsp_ready = 1'b1;
        while ((sbq.size() != 0 || bus.rsp_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain within budget", sbq.size(), 0);
        tick();
    endtask

    // One isolated lookup with hand-computed row/col/result.
    task automatic single(input int r, input logic [47:0] d, input logic [3:0] tag,
                          input logic [31:0] exp_data, input logic [15:0] exp_row,
                          input logic [31:0] exp_col);
        int k;
        bus.req_data = {d, d};
        bus.req_tag  = {tag, tag};
        bus.req_valid = (r == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        check("single req_ready", bus.req_ready, bus.req_valid);
        tick();
        bus.req_valid = 2'b00;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check("directed sbox_row", sbox_row, exp_row);
                check("directed sbox_col", sbox_col, exp_col);
            end
            if (bus.rsp_valid) break;
        end
        check("accept-to-rsp latency", k, 4);
        check("directed rsp_data", bus.rsp_data, exp_data);
        check("directed rsp_id", bus.rsp_id, r[0]);
        check("directed rsp_tag", bus.rsp_tag, tag);
        tick();
    endtask

    initial begin
        int g0;
        int n;
        bus.req_valid = 2'b00;
        bus.req_data  = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;

        // Reset values
        rstn = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset req_ready", bus.req_ready, 0);
        check("reset rsp_valid", bus.rsp_valid, 0);
        check("reset rsp_data", bus.rsp_data, 0);
        check("reset rsp_id", bus.rsp_id, 0);
        check("reset rsp_tag", bus.rsp_tag, 0);
        check("reset sbox_row", sbox_row, 0);
        check("reset sbox_col", sbox_col, 0);
        tick();
        rstn = 1'b1;
        tick();

        // Directed lookups: row 0 col 0, row 3 col 15, row 2 col 0, row 0 col 15
        single(0, 48'h000000000000, 4'h3, 32'hEFA72C4D, 16'h0000, 32'h00000000);
        single(1, 48'hFFFFFFFFFFFF, 4'hA, 32'hD9CE3DCB, 16'hFFFF, 32'hFFFFFFFF);
        single(0, 48'h820820820820, 4'h6, 32'h40DA4917, 16'hAAAA, 32'h00000000);
        single(1, 48'h79E79E79E79E, 4'hC, 32'h7A8F9B17, 16'h0000, 32'hFFFFFFFF);

        // Contention after reset: strict alternation starting at requester 0
        do_reset(2);
        gorder.delete();
        bus.req_tag   = {4'h9, 4'h5};
        bus.req_valid = 2'b11;
        repeat (6) begin
            bus.req_data = {$urandom, $urandom, $urandom};
            tick();
        end
        bus.req_valid = 2'b00;
        check("contention grant count", gorder.size(), 6);
        for (int i = 0; i < 6 && i < gorder.size(); i++) begin
            check("contention grant order", gorder[i], i % 2);
        end
        wait_drain();

        // Back-pressure: exactly DEPTH grants, then pop+grant at full
        do_reset(2);
        gcnt[1] = 0;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b10;
        repeat (10) begin
            rand_data();
            tick();
        end
        check("grants under back-pressure", gcnt[1], DEPTH);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("grant on pop at full", bus.req_ready, 2'b10);
        tick();
        bus.rsp_ready = 1'b0;
        rand_data();
        @(negedge clk);
        check("still full after pop+grant", bus.req_ready, 2'b00);
        tick();
        bus.rsp_ready = 1'b1;
        g0 = gcnt[1];
        repeat (3) begin
            rand_data();
            tick();
        end
        bus.req_valid = 2'b00;
        check("grants resume", gcnt[1] - g0, 3);
        wait_drain();

        // Mid-flight reset drops three accepted lookups
        do_reset(2);
        bus.req_valid = 2'b01;
        repeat (3) begin
            rand_data();
            tick();
        end
        bus.req_valid = 2'b00;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check("post-reset rsp_data", bus.rsp_data, 0);
        check("post-reset sbox_row", sbox_row, 0);
        check("post-reset sbox_col", sbox_col, 0);
        for (int i = 0; i < 8; i++) begin
            check("no rsp after reset", bus.rsp_valid, 0);
            @(negedge clk);
        end
        tick();
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("first contention after reset", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b00;
        wait_drain();

        // Random traffic: 1000 lookups against the golden model
        gcnt[0] = 0;
        gcnt[1] = 0;
        n = 0;
        while (gcnt[0] + gcnt[1] < 1000 && n < 20000) begin
            bus.req_valid = 2'($urandom_range(0, 3));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            tick();
            n++;
        end
        bus.req_valid = 2'b00;
        check("random lookups accepted", (gcnt[0] + gcnt[1] >= 1000), 1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end
endmodule
`default_nettype wire
